// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator SCAN controller.
//   state_e         : controller FSM state encoding (idle / moving / door open)
//   DirUp / DirDown : values carried on the scan direction bit
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMove = 2'd1,
    StDoor = 2'd2
  } state_e;

  localparam logic DirUp   = 1'b1;
  localparam logic DirDown = 1'b0;

endpackage

// File: rtl/elevator_req_bank.sv
// Pending-request bank for the elevator SCAN controller.
// Latches per-floor calls into a pending vector and reports, relative to the
// current floor, whether any request lies above, below, or at that floor.
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   call_i       : per-floor call buttons, sampled every cycle
//   serve_here_i : calls at floor_i are being served directly and must not latch
//   floor_i      : current floor index
//   clr_en_i     : clear the request at clr_floor_i (wins over a same-cycle set)
//   clr_floor_i  : floor whose request is cleared
//   pending_o    : registered pending vector
//   any_above_o  : some request pending strictly above floor_i
//   any_below_o  : some request pending strictly below floor_i
//   here_o       : request pending at floor_i
module elevator_req_bank
  import elevator_pkg::*;
#(
  parameter int unsigned NumFloors = 4,
  parameter int unsigned FloorW    = $clog2(NumFloors)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumFloors-1:0] call_i,
  input  logic                 serve_here_i,
  input  logic [FloorW-1:0]    floor_i,
  input  logic                 clr_en_i,
  input  logic [FloorW-1:0]    clr_floor_i,
  output logic [NumFloors-1:0] pending_o,
  output logic                 any_above_o,
  output logic                 any_below_o,
  output logic                 here_o
);

  logic [NumFloors-1:0] pending_q, pending_d;
  logic [NumFloors-1:0] set_mask, clr_mask;
  logic [31:0]          cur_floor, clr_floor;

  assign cur_floor = 32'(floor_i);
  assign clr_floor = 32'(clr_floor_i);

  always_comb begin
    set_mask    = call_i;
    clr_mask    = '0;
    any_above_o = 1'b0;
    any_below_o = 1'b0;
    for (int unsigned i = 0; i < NumFloors; i++) begin
      if (serve_here_i && (i == cur_floor)) set_mask[i] = 1'b0;
      if (clr_en_i && (i == clr_floor)) clr_mask[i] = 1'b1;
      if (pending_q[i] && (i > cur_floor)) any_above_o = 1'b1;
      if (pending_q[i] && (i < cur_floor)) any_below_o = 1'b1;
    end
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  assign here_o    = pending_q[floor_i];
  assign pending_o = pending_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller using SCAN (sweep) ordering.
// The car keeps moving in its current direction while requests remain ahead,
// reverses only when none are left ahead, and idles when nothing is pending.
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-high reset
//   call         : per-floor call buttons (bit i = floor i)
//   req_led      : pending-request indicators
//   floor_onehot : current floor, one-hot
//   floor_idx    : current floor, binary
//   door_open    : high while the door is open
//   moving       : high while travelling between floors
//   dir_up       : current scan direction (1 = up)
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_FLOORS-1:0]         call,
  output logic [NUM_FLOORS-1:0]         req_led,
  output logic [NUM_FLOORS-1:0]         floor_onehot,
  output logic [$clog2(NUM_FLOORS)-1:0] floor_idx,
  output logic                          door_open,
  output logic                          moving,
  output logic                          dir_up
);

  localparam int unsigned FloorW  = $clog2(NUM_FLOORS);
  localparam int unsigned TravelW = $clog2(TRAVEL_CYCLES) + 1;
  localparam int unsigned DoorW   = $clog2(DOOR_CYCLES) + 1;

  localparam logic [FloorW-1:0]  TopFloor   = FloorW'(NUM_FLOORS - 1);
  localparam logic [TravelW-1:0] TravelLast = TravelW'(TRAVEL_CYCLES - 1);
  localparam logic [DoorW-1:0]   DoorLast   = DoorW'(DOOR_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FloorW-1:0]    floor_q, floor_d;
  logic                 dir_q, dir_d;
  logic [TravelW-1:0]   travel_q, travel_d;
  logic [DoorW-1:0]     door_q, door_d;

  logic [NUM_FLOORS-1:0] pending;
  logic                  any_above, any_below, here;
  logic                  serve_here;
  logic                  clr_en;
  logic [FloorW-1:0]     clr_floor;
  logic [FloorW-1:0]     next_floor;
  logic                  call_here, arrive_hit, ahead, behind;

  // Calls at the current floor are served (door opens / reopens) while the
  // car stands there, so they never become pending.
  assign serve_here = (state_q != StMove);

  elevator_req_bank #(
    .NumFloors (NUM_FLOORS),
    .FloorW    (FloorW)
  ) u_req_bank (
    .clk_i        (clk),
    .rst_i        (rst),
    .call_i       (call),
    .serve_here_i (serve_here),
    .floor_i      (floor_q),
    .clr_en_i     (clr_en),
    .clr_floor_i  (clr_floor),
    .pending_o    (pending),
    .any_above_o  (any_above),
    .any_below_o  (any_below),
    .here_o       (here)
  );

  // Saturating step keeps the car inside the shaft even if direction is stale.
  always_comb begin
    next_floor = floor_q;
    if (dir_q == DirUp) begin
      if (floor_q != TopFloor) next_floor = floor_q + FloorW'(1);
    end else begin
      if (floor_q != '0) next_floor = floor_q - FloorW'(1);
    end
  end

  assign call_here  = call[floor_q];
  assign arrive_hit = pending[next_floor] | call[next_floor];
  assign ahead      = (dir_q == DirUp) ? any_above : any_below;
  assign behind     = (dir_q == DirUp) ? any_below : any_above;

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    travel_d  = '0;
    door_d    = '0;
    clr_en    = 1'b0;
    clr_floor = floor_q;
    unique case (state_q)
      StIdle: begin
        if (call_here || here) begin
          state_d = StDoor;
          clr_en  = 1'b1;
        end else if (any_above || any_below) begin
          state_d = StMove;
          if (!ahead) dir_d = ~dir_q;
        end
      end
      StMove: begin
        if (travel_q == TravelLast) begin
          floor_d = next_floor;
          if (next_floor == '0) begin
            dir_d = DirUp;
          end else if (next_floor == TopFloor) begin
            dir_d = DirDown;
          end
          if (arrive_hit) begin
            state_d   = StDoor;
            clr_en    = 1'b1;
            clr_floor = next_floor;
          end
        end else begin
          travel_d = travel_q + TravelW'(1);
        end
      end
      StDoor: begin
        if (call_here) begin
          door_d = '0;
        end else if (door_q == DoorLast) begin
          if (ahead) begin
            state_d = StMove;
          end else if (behind) begin
            dir_d   = ~dir_q;
            state_d = StMove;
          end else begin
            state_d = StIdle;
          end
        end else begin
          door_d = door_q + DoorW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      floor_q  <= '0;
      dir_q    <= DirUp;
      travel_q <= '0;
      door_q   <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      travel_q <= travel_d;
      door_q   <= door_d;
    end
  end

  assign req_led      = pending;
  assign floor_idx    = floor_q;
  assign floor_onehot = NUM_FLOORS'(1) << floor_q;
  assign door_open    = (state_q == StDoor);
  assign moving       = (state_q == StMove);
  assign dir_up       = dir_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl (4 floors, 4-cycle travel, 6-cycle door).
// A behavioural model tracks mode, floor, direction, time left in the current
// leg/door and the set of waiting floors; every cycle all outputs are compared.
module tb_elevator_scan_ctrl;

  localparam int N  = 4;
  localparam int TC = 4;
  localparam int DC = 6;
  localparam int FW = $clog2(N);

  localparam int MIdle = 0;
  localparam int MMove = 1;
  localparam int MDoor = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  call = '0;
  logic [N-1:0]  req_led, floor_onehot;
  logic [FW-1:0] floor_idx;
  logic          door_open, moving, dir_up;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_scan_ctrl #(
    .NUM_FLOORS    (N),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .call         (call),
    .req_led      (req_led),
    .floor_onehot (floor_onehot),
    .floor_idx    (floor_idx),
    .door_open    (door_open),
    .moving       (moving),
    .dir_up       (dir_up)
  );

  // Reference model state
  int       m_mode;
  int       m_floor;
  bit       m_up;
  int       m_left;
  bit [N-1:0] m_pend;

  function automatic bit wait_above(int f, bit [N-1:0] p);
    for (int i = f + 1; i < N; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit wait_below(int f, bit [N-1:0] p);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode  = MIdle;
    m_floor = 0;
    m_up    = 1'b1;
    m_left  = 0;
    m_pend  = '0;
  endtask

  task automatic model_step(input logic [N-1:0] c);
    bit [N-1:0] np = m_pend;
    int clr = -1;
    bit fwd, back;
    for (int i = 0; i < N; i++)
      if (c[i] && !(m_mode != MMove && i == m_floor)) np[i] = 1'b1;
    fwd  = m_up ? wait_above(m_floor, m_pend) : wait_below(m_floor, m_pend);
    back = m_up ? wait_below(m_floor, m_pend) : wait_above(m_floor, m_pend);
    case (m_mode)
      MIdle: begin
        if (c[m_floor] || m_pend[m_floor]) begin
          m_mode = MDoor; m_left = DC; clr = m_floor;
        end else if (m_pend != '0) begin
          if (!fwd) m_up = !m_up;
          m_mode = MMove; m_left = TC;
        end
      end
      MMove: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          if (m_floor == 0) m_up = 1'b1;
          if (m_floor == N - 1) m_up = 1'b0;
          if (m_pend[m_floor] || c[m_floor]) begin
            m_mode = MDoor; m_left = DC; clr = m_floor;
          end else begin
            m_left = TC;
          end
        end
      end
      default: begin
        if (c[m_floor]) begin
          m_left = DC;
        end else begin
          m_left--;
          if (m_left == 0) begin
            if (fwd) begin
              m_mode = MMove; m_left = TC;
            end else if (back) begin
              m_up = !m_up; m_mode = MMove; m_left = TC;
            end else begin
              m_mode = MIdle;
            end
          end
        end
      end
    endcase
    if (clr >= 0) np[clr] = 1'b0;
    m_pend = np;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] exp_oh = '0;
    exp_oh[m_floor] = 1'b1;
    checks++;
    assert (floor_idx === FW'(m_floor)) else begin
      failures++; $error("FAIL %s floor_idx got=%0d exp=%0d", tag, floor_idx, m_floor);
    end
    checks++;
    assert (floor_onehot === exp_oh) else begin
      failures++; $error("FAIL %s floor_onehot got=%b exp=%b", tag, floor_onehot, exp_oh);
    end
    checks++;
    assert (door_open === (m_mode == MDoor)) else begin
      failures++; $error("FAIL %s door_open got=%b exp=%b", tag, door_open, m_mode == MDoor);
    end
    checks++;
    assert (moving === (m_mode == MMove)) else begin
      failures++; $error("FAIL %s moving got=%b exp=%b", tag, moving, m_mode == MMove);
    end
    checks++;
    assert (dir_up === m_up) else begin
      failures++; $error("FAIL %s dir_up got=%b exp=%b", tag, dir_up, m_up);
    end
    checks++;
    assert (req_led === m_pend) else begin
      failures++; $error("FAIL %s req_led got=%b exp=%b", tag, req_led, m_pend);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive, step model at the rising edge, check at next fall.
  task automatic cycle(input logic [N-1:0] c, input string tag = "run");
    call = c;
    @(posedge clk);
    model_step(c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    call = '0;
    rst  = 1'b1;
    model_reset();
    #1;
    check_all({tag, "_async"});
    @(negedge clk);
    check_all({tag, "_hold"});
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (k < 300 && (moving || door_open || req_led != '0)) begin
      cycle('0);
      k++;
    end
    check_int(tag, int'(moving || door_open || req_led != '0), 0);
  endtask

  initial begin
    int len;
    int stops[$];
    bit sdir[$];
    bit prev;
    int exp_stops [3] = '{2, 3, 0};
    logic [N-1:0] c;

    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Idle with no calls stays parked at floor 0.
    for (int k = 0; k < 50; k++) cycle('0, "idle");

    // Call at the current floor opens the door without latching.
    cycle(4'b0001, "own");
    len = 0;
    for (int k = 0; k < 40 && door_open; k++) begin len++; cycle('0, "own"); end
    check_int("own_door_len", len, DC);

    // Single trip 0 -> 3.
    cycle(4'b1000, "trip");
    len = 0;
    for (int k = 0; k < 100 && !door_open; k++) begin
      cycle('0, "trip");
      if (moving) len++;
    end
    check_int("trip_move_len", len, 3 * TC);
    check_int("trip_door_floor", int'(floor_idx), 3);
    drain("trip_drain");

    // Return to 0, then SCAN ordering with calls injected mid-travel.
    cycle(4'b0001, "home");
    drain("home_drain");
    cycle(4'b1000, "scan");
    for (int k = 0; k < 100 && !(moving && floor_idx == FW'(1)); k++) cycle('0, "scan");
    check_int("scan_reach_f1", int'(moving && floor_idx == FW'(1)), 1);
    prev = door_open;
    cycle(4'b0101, "scan");
    for (int k = 0; k < 300; k++) begin
      if (door_open && !prev) begin
        stops.push_back(int'(floor_idx));
        sdir.push_back(dir_up);
      end
      prev = door_open;
      if (!door_open && !moving) break;
      cycle('0, "scan");
    end
    check_int("scan_nstops", stops.size(), 3);
    for (int i = 0; i < 3 && i < stops.size(); i++) check_int("scan_stop", stops[i], exp_stops[i]);
    if (sdir.size() >= 2) check_int("scan_dir_at_top", int'(sdir[1]), 0);

    // Door restart on a call at the current floor during door cycle 4.
    cycle(4'b0001, "ext");
    len = 0;
    for (int k = 0; k < 40 && door_open; k++) begin
      len++;
      cycle((len == 4) ? 4'b0001 : 4'b0000, "ext");
    end
    check_int("ext_door_len", len, 4 + DC);

    // Reset in the middle of travel 1 -> 2 with floors 2 and 3 waiting.
    cycle(4'b1100, "mrst");
    for (int k = 0; k < 100 && !(moving && floor_idx == FW'(1)); k++) cycle('0, "mrst");
    cycle('0, "mrst");
    check_int("mrst_req_led", int'(req_led), 'hC);
    #2;
    do_reset("mrst");
    check_int("mrst_req_clear", int'(req_led), 0);

    // Random traffic, with one reset in the middle.
    for (int k = 0; k < 2500; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 2) c = N'($urandom);
      else if (r < 4) c = N'(1) << $urandom_range(0, N - 1);
      else c = '0;
      cycle(c, "rand");
      if (k == 1200) do_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors (>=2).
REQ-002 Parameter TRAVEL_CYCLES, default 8, clock cycles to travel one floor (>=1).
REQ-003 Parameter DOOR_CYCLES, default 16, clock cycles the door stays open (>=1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 call  in  NUM_FLOORS  per-floor call buttons, level-sampled each cycle; bit i = floor i.
REQ-007 req_led  out  NUM_FLOORS  pending-request indicators, bit i set while floor i is pending.
REQ-008 floor_onehot  out  NUM_FLOORS  current floor, exactly one bit set.
REQ-009 floor_idx  out  $clog2(NUM_FLOORS)  current floor index, binary.
REQ-010 door_open  out  1  high while in DOOR state.
REQ-011 moving  out  1  high while in MOVE state.
REQ-012 dir_up  out  1  current scan direction (1 = up, 0 = down).

Function
REQ-013 All outputs SHALL be registered; none combinationally depends on call.
REQ-014 States: IDLE, MOVE, DOOR; exactly one active.
REQ-015 Request latch: call[i]=1 sets pending[i] next cycle, except floor i = floor_idx while in DOOR or IDLE (served instead, never latched).
REQ-016 pending[i] SHALL clear in the cycle DOOR is entered at floor i; clear wins over simultaneous set.
REQ-017 IDLE, no pending, no call: remain IDLE, dir_up unchanged.
REQ-018 IDLE, call at current floor: enter DOOR next cycle, no movement.
REQ-019 IDLE, pending elsewhere: select direction -- keep dir_up if any pending lies ahead in it, else reverse -- and enter MOVE.
REQ-020 MOVE: travel counter runs TRAVEL_CYCLES cycles, then floor_idx steps by +1 (up) or -1 (down) and counter reloads.
REQ-021 On arrival, pending at new floor: enter DOOR in that same update; else remain MOVE in same direction.
REQ-022 floor_idx SHALL never go below 0 or above NUM_FLOORS-1; direction is forced to point inward at either end.
REQ-023 DOOR: door_open high exactly DOOR_CYCLES cycles; a call at current floor during DOOR restarts the door counter.
REQ-024 DOOR expiry: pending ahead in dir_up -> MOVE same direction; else pending behind -> toggle dir_up, MOVE; else IDLE.
REQ-025 Requests arriving during MOVE for floors already passed are served on the return sweep (SCAN order).
REQ-026 Counter widths SHALL be $clog2 of the respective parameter plus one; no overflow wrap in normal operation.

Reset
REQ-027 On rst: state IDLE, floor_idx 0, floor_onehot 1, pending 0, req_led 0, door_open 0, moving 0, dir_up 1, counters 0.
REQ-028 rst asserted mid-MOVE or mid-DOOR SHALL abandon the operation immediately; no request survives reset.
REQ-029 First state change after rst deassertion occurs on the next rising clk edge.

Structure
REQ-030 Shared package elevator_pkg SHALL hold the state encoding (IDLE/MOVE/DOOR) and direction constants.
REQ-031 One sub-module, elevator_req_bank, SHALL hold pending latch/clear logic and produce any_above, any_below, here flags for a given floor_idx.
REQ-032 Controller FSM, travel/door counters and floor register reside in elevator_scan_ctrl.

Verification (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=6)
REQ-033 Reset idle: rst then no calls 50 cycles -> floor_idx 0, door_open 0, moving 0, req_led 0000.
REQ-034 Call at own floor: call[0] one cycle while IDLE at 0 -> door_open high 6 cycles, req_led stays 0000, back to IDLE.
REQ-035 Single trip: call[3] at floor 0 -> moving 12 cycles, floor_idx 1,2,3 every 4 cycles, door_open at 3, req_led[3] clears on door entry.
REQ-036 SCAN order: at floor 0 call[3]; at floor 1 in MOVE call[0] and call[2] -> stops 2 then 3, dir_up toggles to 0, then stops 0.
REQ-037 Door extend: call[floor_idx] on cycle 4 of DOOR -> door_open lasts 4+6 cycles total.
REQ-038 Reset mid-MOVE: rst during travel 1->2 with req_led 1100 -> all outputs at reset values next cycle, req_led 0000.
